// File: rtl/alu_rr_scheduler_pkg.sv
// Shared definitions for the two-requester ALU scheduler: datapath widths,
// ALU mode encodings, scheduler FSM states and the latched operation bundle.
package alu_rr_scheduler_pkg;

  localparam int WIDTH  = 8;
  localparam int CTRL_W = 3;

  localparam logic MODE_ARITH = 1'b0;
  localparam logic MODE_LOGIC = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              cin;
    logic [CTRL_W-1:0] ctrl;
    logic              mode;
  } alu_op_t;

endpackage

// File: rtl/alu_rr_scheduler_arb.sv
// Two-way round-robin arbiter. Grant is combinational and one-hot;
// the remembered winner only moves when a grant is actually issued.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_grant;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Resetting to 1 lets requester 0 win the first contention.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (|gnt) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one external combinational ALU between two requesters with
// round-robin arbitration, registered ALU drives and a tagged response port.
module alu_rr_scheduler
  import alu_rr_scheduler_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic              req0_cin,
  input  logic              req1_cin,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic              req0_mode,
  input  logic              req1_mode,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic              alu_c_in,
  output logic [CTRL_W-1:0] alu_control_line,
  output logic              alu_mode_select,
  input  logic [WIDTH-1:0]  alu_out,
  input  logic              alu_c_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WIDTH-1:0]  rsp_out,
  output logic              rsp_cout,
  output logic              rsp_id
);

  state_t     state;
  logic       id;
  logic       arb_en;
  logic [1:0] gnt;
  alu_op_t    sel_op;

  // Grants are only offered in IDLE and never while reset is held.
  assign arb_en    = (state == ST_IDLE) && !rst;
  assign req_ready = gnt;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .en  (arb_en),
    .gnt (gnt)
  );

  always_comb begin
    sel_op = gnt[1] ? {req1_a, req1_b, req1_cin, req1_ctrl, req1_mode}
                    : {req0_a, req0_b, req0_cin, req0_ctrl, req0_mode};
  end

  // The ALU drives are deliberately left holding their last operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      id               <= 1'b0;
      rsp_valid        <= 1'b0;
      rsp_out          <= '0;
      rsp_cout         <= 1'b0;
      rsp_id           <= 1'b0;
      alu_a            <= '0;
      alu_b            <= '0;
      alu_c_in         <= 1'b0;
      alu_control_line <= '0;
      alu_mode_select  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|gnt) begin
            alu_a            <= sel_op.a;
            alu_b            <= sel_op.b;
            alu_c_in         <= sel_op.cin;
            alu_control_line <= sel_op.ctrl;
            alu_mode_select  <= sel_op.mode;
            id               <= gnt[1];
            state            <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_out   <= alu_out;
          rsp_cout  <= alu_c_out;
          rsp_id    <= id;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler: a behavioural ALU closes the loop,
// accepted requests queue their expected response, a monitor pops and compares.
module tb_alu_rr_scheduler;
  import alu_rr_scheduler_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [WIDTH-1:0]  ra [2];
  logic [WIDTH-1:0]  rb [2];
  logic              rcin [2];
  logic [CTRL_W-1:0] rctrl [2];
  logic              rmode [2];
  logic [WIDTH-1:0]  alu_a, alu_b, alu_out;
  logic              alu_c_in, alu_mode_select, alu_c_out;
  logic [CTRL_W-1:0] alu_control_line;
  logic              rsp_valid, rsp_ready, rsp_cout, rsp_id;
  logic [WIDTH-1:0]  rsp_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             id;
    int               cyc;
  } exp_t;

  exp_t exp_q[$];
  int   grant_id_q[$];
  int   grant_cyc_q[$];
  logic [1:0] acc = 2'b00;
  logic model_last = 1'b1;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic [WIDTH-1:0] prev_out = '0;
  logic prev_cout = 1'b0;
  logic prev_id = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_rr_scheduler dut (
    .clk (clk), .rst (rst), .req_valid (req_valid), .req_ready (req_ready),
    .req0_a (ra[0]), .req1_a (ra[1]), .req0_b (rb[0]), .req1_b (rb[1]),
    .req0_cin (rcin[0]), .req1_cin (rcin[1]),
    .req0_ctrl (rctrl[0]), .req1_ctrl (rctrl[1]),
    .req0_mode (rmode[0]), .req1_mode (rmode[1]),
    .alu_a (alu_a), .alu_b (alu_b), .alu_c_in (alu_c_in),
    .alu_control_line (alu_control_line), .alu_mode_select (alu_mode_select),
    .alu_out (alu_out), .alu_c_out (alu_c_out),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready),
    .rsp_out (rsp_out), .rsp_cout (rsp_cout), .rsp_id (rsp_id)
  );

  // Reference ALU: returns {carry, result} for a given operation.
  function automatic logic [WIDTH:0] alu_model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic cin, input logic [CTRL_W-1:0] ctrl,
                                               input logic mode);
    logic [WIDTH:0] ea, eb, ec, r;
    ea = {1'b0, a};
    eb = {1'b0, b};
    ec = {{WIDTH{1'b0}}, cin};
    r  = '0;
    if (mode == MODE_ARITH) begin
      case (ctrl)
        3'd0: r = ea + eb + ec;
        3'd1: r = ea + {1'b0, ~b} + ec;
        3'd2: r = ea + ec;
        3'd3: r = ea + {1'b0, {WIDTH{1'b1}}} + ec;
        3'd4: r = eb + ec;
        3'd5: r = ea + ea + ec;
        3'd6: r = ea + {1'b0, a & b} + ec;
        default: r = {1'b0, ~a} + ec;
      endcase
    end else if (mode == MODE_LOGIC) begin
      case (ctrl)
        3'd0: r = {1'b0, a & b};
        3'd1: r = {1'b0, a | b};
        3'd2: r = {1'b0, a ^ b};
        3'd3: r = {1'b0, ~(a & b)};
        3'd4: r = {1'b0, ~(a | b)};
        3'd5: r = {1'b0, ~(a ^ b)};
        3'd6: r = {1'b0, ~a};
        default: r = {1'b0, b};
      endcase
    end
    return r;
  endfunction

  assign {alu_c_out, alu_out} = alu_model(alu_a, alu_b, alu_c_in, alu_control_line, alu_mode_select);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic [CTRL_W-1:0] ctrl, input logic mode);
    ra[i] = a; rb[i] = b; rcin[i] = cin; rctrl[i] = ctrl; rmode[i] = mode;
    req_valid[i] = 1'b1;
  endtask

  task automatic randomOps(input int i);
    applyStimulus(i, WIDTH'($urandom), WIDTH'($urandom), 1'($urandom),
                  CTRL_W'($urandom), 1'($urandom));
  endtask

  task automatic waitGrant(input int i, input string name);
    logic found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin found = 1'b1; break; end
    end
    checkOutput(name, found, 1);
  endtask

  task automatic waitRsp(input string name);
    logic found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) begin found = 1'b1; break; end
    end
    checkOutput(name, found, 1);
  endtask

  task automatic drain();
    logic done = 1'b0;
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!rsp_valid && exp_q.size() == 0) begin done = 1'b1; break; end
    end
    checkOutput("drain", done, 1);
  endtask

  task automatic doReset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: scores grants and responses; reset discards anything in flight.
  always @(negedge clk) begin
    logic           g;
    logic [WIDTH:0] r;
    exp_t           e;
    acc = 2'b00;
    if (rst) begin
      exp_q.delete();
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      model_last = 1'b1;
    end else begin
      if (req_ready != 2'b00) begin
        checkOutput("ready_onehot", $countones(req_ready), 1);
        checkOutput("ready_without_valid", req_ready & ~req_valid, 0);
      end
      if ((req_ready & req_valid) != 2'b00) begin
        g = req_ready[1];
        if (req_valid == 2'b11) checkOutput("rr_alternation", g, !model_last);
        model_last = g;
        acc = req_ready & req_valid;
        r = alu_model(ra[g], rb[g], rcin[g], rctrl[g], rmode[g]);
        e.out = r[WIDTH-1:0]; e.cout = r[WIDTH]; e.id = g; e.cyc = cyc;
        exp_q.push_back(e);
        grant_id_q.push_back(int'(g));
        grant_cyc_q.push_back(cyc);
      end
      if (rsp_valid) begin
        checkOutput("ready_during_resp", req_ready, 0);
        if (prev_valid && !prev_ready) begin
          checkOutput("hold_out", rsp_out, prev_out);
          checkOutput("hold_cout", rsp_cout, prev_cout);
          checkOutput("hold_id", rsp_id, prev_id);
        end else if (exp_q.size() == 0) begin
          checkOutput("rsp_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rsp_out", rsp_out, e.out);
          checkOutput("rsp_cout", rsp_cout, e.cout);
          checkOutput("rsp_id", rsp_id, e.id);
          checkOutput("rsp_latency", cyc - e.cyc, 2);
        end
      end
      prev_valid = rsp_valid; prev_ready = rsp_ready;
      prev_out = rsp_out; prev_cout = rsp_cout; prev_id = rsp_id;
    end
  end

  initial begin
    int start;
    logic [WIDTH:0] m;
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      ra[i] = '0; rb[i] = '0; rcin[i] = 1'b0; rctrl[i] = '0; rmode[i] = 1'b0;
    end

    // Reset held with both requesters asking.
    req_valid = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_rsp_valid", rsp_valid, 0);
      checkOutput("rst_rsp_out", rsp_out, 0);
      checkOutput("rst_rsp_cout", rsp_cout, 0);
      checkOutput("rst_rsp_id", rsp_id, 0);
      checkOutput("rst_alu_drives", {alu_a, alu_b, alu_c_in, alu_control_line, alu_mode_select}, 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = 2'b00;

    // Single op from requester 0.
    @(posedge clk); #1;
    applyStimulus(0, 8'd2, 8'd3, 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    checkOutput("t2_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("t2_alu_a", alu_a, 2);
    checkOutput("t2_alu_b", alu_b, 3);
    checkOutput("t2_rsp_early", rsp_valid, 0);
    @(negedge clk);
    m = alu_model(8'd2, 8'd3, 1'b0, 3'd0, 1'b0);
    checkOutput("t2_rsp_valid", rsp_valid, 1);
    checkOutput("t2_rsp_id", rsp_id, 0);
    checkOutput("t2_rsp_out", rsp_out, m[WIDTH-1:0]);
    drain();

    // Continuous contention: grants alternate 0,1,0,1 every third cycle.
    doReset(1);
    randomOps(0);
    randomOps(1);
    start = grant_id_q.size();
    repeat (16) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) if (acc[i]) randomOps(i);
    end
    drain();
    checkOutput("t3_grant_count", (grant_id_q.size() - start) >= 4, 1);
    for (int k = 0; k < 4; k++) begin
      if (start + k < grant_id_q.size()) begin
        checkOutput("t3_order", grant_id_q[start+k], k % 2);
        if (k > 0) checkOutput("t3_spacing", grant_cyc_q[start+k] - grant_cyc_q[start+k-1], 3);
      end
    end

    // Backpressure: response held five cycles while both requesters wait.
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    randomOps(0);
    waitGrant(0, "t4_grant");
    @(posedge clk); #1;
    randomOps(0);
    randomOps(1);
    waitRsp("t4_rsp");
    repeat (5) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("t4_held_valid", rsp_valid, 1);
      checkOutput("t4_held_no_ready", req_ready, 0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("t4_no_grant_in_resp", req_ready, 0);
    @(negedge clk);
    checkOutput("t4_accept_after", req_ready != 2'b00, 1);
    drain();

    // Sweep of every mode/control pair on requester 1.
    for (int md = 0; md < 2; md++) begin
      for (int c = 0; c < 8; c++) begin
        @(posedge clk); #1;
        applyStimulus(1, 8'hFF, 8'h01, 1'b1, CTRL_W'(c), 1'(md));
        waitGrant(1, "t5_grant");
        @(posedge clk); #1;
        req_valid = 2'b00;
        waitRsp("t5_rsp");
      end
    end
    drain();

    // Reset in EXEC, then in RESP.
    @(posedge clk); #1;
    randomOps(0);
    @(negedge clk);
    checkOutput("t6_grant_a", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_exec_abort", rsp_valid, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    randomOps(0);
    @(negedge clk);
    checkOutput("t6_idle_after", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    waitRsp("t6_rsp");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_resp_abort", rsp_valid, 0);
    checkOutput("t6_resp_out_clr", rsp_out, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    randomOps(0);
    randomOps(1);
    @(negedge clk);
    checkOutput("t6_rr_first", req_ready, 2'b01);
    drain();

    // Random traffic with random consumer backpressure.
    repeat (400) begin
      @(posedge clk); #1;
      rsp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          if ($urandom_range(0, 3) != 0) randomOps(i);
          else req_valid[i] = 1'b0;
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          randomOps(i);
        end
      end
    end
    drain();
    checkOutput("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
